// File: rtl/ibex_rf_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the register-file write-port arbiter.
package ibex_rf_wr_arb_pkg;

  localparam int unsigned RfDataWidth  = 32;
  localparam int unsigned RfAddrWidthI = 5;
  localparam int unsigned RfAddrWidthE = 4;
  localparam int unsigned RfNumWordsI  = 32;
  localparam int unsigned RfNumWordsE  = 16;

  typedef enum logic [0:0] {
    RF_ARB_CLEAR = 1'b0,
    RF_ARB_RUN   = 1'b1
  } rf_arb_state_e;

  typedef struct packed {
    logic [4:0]             addr;
    logic [RfDataWidth-1:0] wdata;
  } rf_wr_req_t;

  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? RfAddrWidthE : RfAddrWidthI;
  endfunction

  function automatic int unsigned rf_num_words(input bit rv32e);
    return rv32e ? RfNumWordsE : RfNumWordsI;
  endfunction

  // RV32E has no x16..x31, so bit 4 is dropped before any compare or write
  function automatic logic [4:0] rf_addr_mask(input bit rv32e, input logic [4:0] addr);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_wr_arbiter_if.sv
// Writeback request/grant bundle for the EX and LSU sources.
interface ibex_rf_wr_arbiter_if #(
  parameter int unsigned DataWidth = 32
);

  logic                 ex_req;
  logic [4:0]           ex_addr;
  logic [DataWidth-1:0] ex_wdata;
  logic                 ex_gnt;
  logic                 lsu_req;
  logic [4:0]           lsu_addr;
  logic [DataWidth-1:0] lsu_wdata;
  logic                 lsu_gnt;

  modport master (
    output ex_req, ex_addr, ex_wdata, lsu_req, lsu_addr, lsu_wdata,
    input  ex_gnt, lsu_gnt
  );

  modport slave (
    input  ex_req, ex_addr, ex_wdata, lsu_req, lsu_addr, lsu_wdata,
    output ex_gnt, lsu_gnt
  );

endinterface

// File: rtl/ibex_rf_wr_arbiter_clear_seq.sv
// Post-reset sweep address generator; done_o marks the last writable register.
module ibex_rf_clear_seq
  import ibex_rf_wr_arb_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [4:0] addr_o,
  output logic       done_o
);

  localparam int unsigned     AddrW    = rf_addr_width(RV32E);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(rf_num_words(RV32E) - 1);

  logic [AddrW-1:0] addr_r;

  // sweep counter starts at x1 because x0 is never written
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_r <= AddrW'(1);
    end else if (en_i) begin
      addr_r <= addr_r + AddrW'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr_o = 5'(addr_r);
  assign done_o = en_i && (addr_r == LastAddr);

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter (EX vs LSU) with post-reset clear sweep.
// Optional anti-starvation for EX is built when IBEX_RF_WR_ARB_STARVE_EN is defined.
module ibex_rf_wr_arbiter
  import ibex_rf_wr_arb_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = RfDataWidth,
  parameter int unsigned MaxStall  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_rf_wr_arbiter_if.slave  wr_bus,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 init_done_o
);

  if ((MaxStall < 1) || (MaxStall > 15)) begin : g_bad_max_stall
    $error("MaxStall must be within 1..15");
  end

  rf_arb_state_e        state_r, state_s;
  logic [4:0]           sweep_addr_s;
  logic                 sweep_done_s;
  logic                 ex_prio_s, ex_gnt_s, lsu_gnt_s;
  logic                 stage_valid_s;
  rf_wr_req_t           stage_s;
  logic                 rf_we_r;
  logic [4:0]           rf_waddr_r;
  logic [DataWidth-1:0] rf_wdata_r;

  ibex_rf_clear_seq #(.RV32E(RV32E)) u_clear_seq (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_r == RF_ARB_CLEAR),
    .addr_o (sweep_addr_s),
    .done_o (sweep_done_s)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= RF_ARB_CLEAR;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: RUN is only left through reset
  always_comb begin
    state_s = state_r;
    case (state_r)
      RF_ARB_CLEAR: begin
        if (sweep_done_s) state_s = RF_ARB_RUN;
        else              state_s = RF_ARB_CLEAR;
      end
      RF_ARB_RUN:   state_s = RF_ARB_RUN;
      default:      state_s = RF_ARB_CLEAR;
    endcase
  end

`ifdef IBEX_RF_WR_ARB_STARVE_EN
  localparam logic [3:0] StallMax = 4'(MaxStall);
  logic [3:0] stall_cnt_r;

  // counts consecutive EX denials, saturating at the priority threshold
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_r <= 4'd0;
    end else if (!wr_bus.ex_req || ex_gnt_s) begin
      stall_cnt_r <= 4'd0;
    end else if (stall_cnt_r < StallMax) begin
      stall_cnt_r <= stall_cnt_r + 4'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign ex_prio_s = wr_bus.ex_req && (stall_cnt_r == StallMax);
`else
  assign ex_prio_s = 1'b0;
`endif

  // grant logic: LSU first unless EX has been starved long enough
  always_comb begin
    ex_gnt_s  = 1'b0;
    lsu_gnt_s = 1'b0;
    if (rst_ni && (state_r == RF_ARB_RUN)) begin
      lsu_gnt_s = wr_bus.lsu_req && !ex_prio_s;
      ex_gnt_s  = wr_bus.ex_req && !lsu_gnt_s;
    end else begin
      ex_gnt_s  = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  assign wr_bus.ex_gnt  = ex_gnt_s;
  assign wr_bus.lsu_gnt = lsu_gnt_s;

  // select what enters the output stage this cycle
  always_comb begin
    stage_valid_s = 1'b0;
    stage_s       = '0;
    if (state_r == RF_ARB_CLEAR) begin
      stage_valid_s = 1'b1;
      stage_s.addr  = sweep_addr_s;
      stage_s.wdata = '0;
    end else if (lsu_gnt_s) begin
      stage_valid_s = 1'b1;
      stage_s.addr  = rf_addr_mask(RV32E, wr_bus.lsu_addr);
      stage_s.wdata = RfDataWidth'(wr_bus.lsu_wdata);
    end else if (ex_gnt_s) begin
      stage_valid_s = 1'b1;
      stage_s.addr  = rf_addr_mask(RV32E, wr_bus.ex_addr);
      stage_s.wdata = RfDataWidth'(wr_bus.ex_wdata);
    end else begin
      stage_valid_s = 1'b0;
    end
  end

  // output stage; address/data only move on a real (nonzero) write
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= '0;
    end else begin
      rf_we_r <= stage_valid_s && (stage_s.addr != 5'd0);
      if (stage_valid_s && (stage_s.addr != 5'd0)) begin
        rf_waddr_r <= stage_s.addr;
        rf_wdata_r <= DataWidth'(stage_s.wdata);
      end else begin
        rf_waddr_r <= rf_waddr_r;
        rf_wdata_r <= rf_wdata_r;
      end
    end
  end

  assign rf_we_o     = rf_we_r;
  assign rf_waddr_o  = rf_waddr_r;
  assign rf_wdata_o  = rf_wdata_r;
  assign init_done_o = rst_ni && (state_r == RF_ARB_RUN);
  assign hazard_a_o  = init_done_o && rf_we_r &&
                       (rf_addr_mask(RV32E, raddr_a_i) == rf_waddr_r);
  assign hazard_b_o  = init_done_o && rf_we_r &&
                       (rf_addr_mask(RV32E, raddr_b_i) == rf_waddr_r);

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Directed bench for ibex_rf_wr_arbiter: RV32I instance plus an RV32E instance.
module tb_ibex_rf_wr_arbiter;

`ifdef IBEX_RF_WR_ARB_STARVE_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  rf_waddr, e_rf_waddr;
  logic [31:0] rf_wdata, e_rf_wdata;
  logic        rf_we, e_rf_we;
  logic [4:0]  raddr_a, raddr_b, e_raddr_a, e_raddr_b;
  logic        hz_a, hz_b, e_hz_a, e_hz_b;
  logic        init_done, e_init_done;
  int          n_checks = 0;
  int          n_errors = 0;

  ibex_rf_wr_arbiter_if #(.DataWidth(32)) bus ();
  ibex_rf_wr_arbiter_if #(.DataWidth(32)) bus_e ();

  always #5 clk_i = ~clk_i;

  ibex_rf_wr_arbiter #(.RV32E(1'b0), .DataWidth(32), .MaxStall(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_bus(bus),
    .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .hazard_a_o(hz_a), .hazard_b_o(hz_b), .init_done_o(init_done)
  );

  ibex_rf_wr_arbiter #(.RV32E(1'b1), .DataWidth(32), .MaxStall(4)) dut_e (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_bus(bus_e),
    .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .rf_we_o(e_rf_we),
    .raddr_a_i(e_raddr_a), .raddr_b_i(e_raddr_b),
    .hazard_a_o(e_hz_a), .hazard_b_o(e_hz_b), .init_done_o(e_init_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // LSU request is held during the sweep to show it is not granted early
  task automatic sweep_check();
    for (int k = 1; k <= 31; k++) begin
      step();
      check_eq("sweep_we", rf_we, 32'd1);
      check_eq("sweep_addr", rf_waddr, k);
      check_eq("sweep_data", rf_wdata, 32'd0);
      check_eq("sweep_done", init_done, (k == 31));
      check_eq("sweep_lsu_gnt", bus.lsu_gnt, (k == 31));
      check_eq("sweep_ex_gnt", bus.ex_gnt, 32'd0);
      check_eq("e_sweep_we", e_rf_we, (k <= 15));
      check_eq("e_sweep_done", e_init_done, (k >= 15));
      if (k <= 15) check_eq("e_sweep_addr", e_rf_waddr, k);
    end
    bus.lsu_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    bus.ex_req = 1'b0;   bus.ex_addr = 5'd0;   bus.ex_wdata = 32'd0;
    bus.lsu_req = 1'b1;  bus.lsu_addr = 5'd9;  bus.lsu_wdata = 32'h99;
    bus_e.ex_req = 1'b0; bus_e.ex_addr = 5'd0; bus_e.ex_wdata = 32'd0;
    bus_e.lsu_req = 1'b0; bus_e.lsu_addr = 5'd0; bus_e.lsu_wdata = 32'd0;
    raddr_a = 5'd0; raddr_b = 5'd0; e_raddr_a = 5'd0; e_raddr_b = 5'd0;

    step();
    step();
    check_eq("rst_we", rf_we, 32'd0);
    check_eq("rst_waddr", rf_waddr, 32'd0);
    check_eq("rst_done", init_done, 32'd0);
    check_eq("rst_lsu_gnt", bus.lsu_gnt, 32'd0);
    rst_ni = 1'b1;
    sweep_check();

    // both sources request: LSU first, EX the cycle after
    bus.ex_req = 1'b1;  bus.ex_addr = 5'd5;  bus.ex_wdata = 32'h11;
    bus.lsu_req = 1'b1; bus.lsu_addr = 5'd6; bus.lsu_wdata = 32'h22;
    #1;
    check_eq("both_lsu_gnt", bus.lsu_gnt, 32'd1);
    check_eq("both_ex_gnt", bus.ex_gnt, 32'd0);
    step();
    bus.lsu_req = 1'b0; raddr_b = 5'd6; raddr_a = 5'd5;
    #1;
    check_eq("wr6_addr", rf_waddr, 32'd6);
    check_eq("wr6_data", rf_wdata, 32'h22);
    check_eq("wr6_we", rf_we, 32'd1);
    check_eq("wr6_ex_gnt", bus.ex_gnt, 32'd1);
    check_eq("wr6_haz_b", hz_b, 32'd1);
    check_eq("wr6_haz_a", hz_a, 32'd0);
    step();
    bus.ex_req = 1'b0;
    #1;
    check_eq("wr5_addr", rf_waddr, 32'd5);
    check_eq("wr5_data", rf_wdata, 32'h11);
    check_eq("wr5_we", rf_we, 32'd1);
    check_eq("wr5_haz_a", hz_a, 32'd1);
    raddr_a = 5'd0; raddr_b = 5'd0;

    // sustained contention: EX wins on cycle 5 only with anti-starvation
    bus.lsu_req = 1'b1; bus.lsu_addr = 5'd10; bus.lsu_wdata = 32'hA0;
    bus.ex_req = 1'b1;  bus.ex_addr = 5'd11;  bus.ex_wdata = 32'hB0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      check_eq($sformatf("starve_lsu_gnt_%0d", i), bus.lsu_gnt, !(StarveEn && (i == 5)));
      check_eq($sformatf("starve_ex_gnt_%0d", i), bus.ex_gnt, (StarveEn && (i == 5)));
      step();
    end
    bus.lsu_req = 1'b0; bus.ex_req = 1'b0;

    // write to x0 is granted but never enables the register file
    bus.ex_req = 1'b1; bus.ex_addr = 5'd0; bus.ex_wdata = 32'hDEADBEEF;
    raddr_a = 5'd10;
    #1;
    check_eq("x0_ex_gnt", bus.ex_gnt, 32'd1);
    check_eq("a0_haz_a", hz_a, 32'd1);
    step();
    bus.ex_req = 1'b0; raddr_a = 5'd0;
    #1;
    check_eq("x0_we", rf_we, 32'd0);
    check_eq("x0_hold_addr", rf_waddr, 32'd10);
    check_eq("x0_hold_data", rf_wdata, 32'hA0);
    check_eq("x0_haz_a", hz_a, 32'd0);

    // x7 write followed by a matching read on port B
    bus.ex_req = 1'b1; bus.ex_addr = 5'd7; bus.ex_wdata = 32'h77;
    #1;
    check_eq("x7_ex_gnt", bus.ex_gnt, 32'd1);
    step();
    bus.ex_req = 1'b0; raddr_b = 5'd7; raddr_a = 5'd8;
    #1;
    check_eq("x7_addr", rf_waddr, 32'd7);
    check_eq("x7_haz_b", hz_b, 32'd1);
    check_eq("x7_haz_a", hz_a, 32'd0);
    step();
    check_eq("x7_haz_b_gone", hz_b, 32'd0);
    raddr_b = 5'd0; raddr_a = 5'd0;

    // RV32E drops address bit 4
    bus_e.lsu_req = 1'b1; bus_e.lsu_addr = 5'h13; bus_e.lsu_wdata = 32'h55;
    e_raddr_a = 5'h13;
    #1;
    check_eq("e_lsu_gnt", bus_e.lsu_gnt, 32'd1);
    step();
    bus_e.lsu_req = 1'b0;
    #1;
    check_eq("e_waddr", e_rf_waddr, 32'd3);
    check_eq("e_wdata", e_rf_wdata, 32'h55);
    check_eq("e_we", e_rf_we, 32'd1);
    check_eq("e_haz_a", e_hz_a, 32'd1);
    e_raddr_a = 5'd0;

    // reset during a granted write drops it and restarts the sweep
    bus.lsu_req = 1'b1; bus.lsu_addr = 5'd12; bus.lsu_wdata = 32'h0C;
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_gnt", bus.lsu_gnt, 32'd0);
    step();
    check_eq("mid_rst_we", rf_we, 32'd0);
    check_eq("mid_rst_done", init_done, 32'd0);
    check_eq("mid_rst_waddr", rf_waddr, 32'd0);
    bus.lsu_addr = 5'd9; bus.lsu_wdata = 32'h99;
    rst_ni = 1'b1;
    sweep_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wr_arbiter.md
Name: ibex_rf_wr_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the EX/ALU result and late LSU load data.
- After every reset, sweeps every writable register to zero before any source is granted.
- Drives the register file write port (waddr/wdata/we) through a one-cycle registered output stage.
- Flags read-after-write hazards against the write still in flight in that stage.

Parameters:
- RV32E, 0, 1 selects 16 registers (4-bit internal address); 0 selects 32 registers.
- DataWidth, 32, write data width.
- MaxStall, 4, consecutive cycles EX may be denied before it is granted priority for one cycle; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- ex_req_i  in  1  EX write request
- ex_addr_i  in  5  EX destination register
- ex_wdata_i  in  DataWidth  EX write data
- ex_gnt_o  out  1  EX request accepted this cycle
- lsu_req_i  in  1  LSU write request
- lsu_addr_i  in  5  LSU destination register
- lsu_wdata_i  in  DataWidth  LSU write data
- lsu_gnt_o  out  1  LSU request accepted this cycle
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- rf_we_o  out  1  register file write enable
- raddr_a_i  in  5  read port A address (decode stage)
- raddr_b_i  in  5  read port B address (decode stage)
- hazard_a_o  out  1  read A hits the write in flight
- hazard_b_o  out  1  read B hits the write in flight
- init_done_o  out  1  clear sweep complete

Behaviour:
- Reset: one clock, synchronous active-low. Sampled rst_ni=0 forces FSM=CLEAR, sweep address=1, stall counter=0, output stage invalid. Outputs read 0 while held in reset (rf_*, gnt, hazard, init_done). Reset may occur mid-operation; a pending write is dropped.
- FSM CLEAR:
  - Each cycle stages a write of 0 to the sweep address, then increments it.
  - After address NumWords-1 is staged, moves to RUN. NumWords=16 or 32.
  - Sweep takes NumWords-1 cycles; rf_we_o follows one cycle later.
  - Both grants held at 0; init_done_o=0.
- FSM RUN: init_done_o=1; the FSM stays in RUN until reset.
- Arbitration (combinational, same cycle):
  - Default priority is LSU over EX.
  - If the stall counter equals MaxStall and ex_req_i=1, EX wins and LSU is denied.
  - Exactly one grant is asserted when any request is present.
- Stall counter:
  - Increments when ex_req_i=1 and EX is denied.
  - Clears on an EX grant or when ex_req_i=0.
  - Saturates at MaxStall.
- Requester handshake: a requester must hold req/addr/wdata stable until granted. Data is consumed in the grant cycle.
- Output stage:
  - Granted addr/wdata are registered, so rf_* appear on the cycle after the grant.
  - rf_we_o=1 only when a write was granted (or swept) and the registered address is nonzero. Grants to x0 complete but never assert rf_we_o.
  - RV32E: address bit 4 is masked to 0 before use.
  - rf_waddr_o/rf_wdata_o hold their last value when rf_we_o=0.
- Hazards: hazard_x_o = rf_we_o && (raddr_x_i masked == rf_waddr_o). They are combinational, and are 0 for address 0 and during CLEAR.

Optional Feature:
- Macro: IBEX_RF_WR_ARB_STARVE_EN.
- Defined: the MaxStall anti-starvation counter and the EX-priority override above are built.
- Undefined: pure fixed priority LSU over EX, with no counter logic. MaxStall is ignored, and EX may be denied indefinitely while lsu_req_i=1.

Decomposition:
- Package ibex_rf_wr_arb_pkg holds:
  - rf_arb_state_e enum {RF_ARB_CLEAR, RF_ARB_RUN};
  - rf_wr_req_t struct (addr, wdata);
  - localparams for address width and word count as functions of RV32E.
- Sub-module ibex_rf_clear_seq contains the sweep address counter and the CLEAR→RUN done pulse, instantiated once.

Test Plan:
- Reset release, RV32E=0 → rf_we_o pulses at addresses 1..31 with wdata 0 on consecutive cycles; init_done_o rises 31 cycles after release; no grants before it rises.
- RUN, both request (ex addr 5 data 0x11, lsu addr 6 data 0x22) → lsu_gnt_o=1, ex_gnt_o=0. Next cycle: rf_waddr_o=6, rf_wdata_o=0x22, rf_we_o=1, ex_gnt_o=1. Following cycle: write 5/0x11.
- With STARVE_EN and MaxStall=4, lsu_req_i held high and ex_req_i high → ex_gnt_o=1 on the 5th cycle; counter returns to 0; LSU is granted again the cycle after.
- EX write to x0 with data 0xDEADBEEF → ex_gnt_o=1, rf_we_o stays 0; raddr_a_i=0 → hazard_a_o=0.
- Write x7 granted, raddr_b_i=7 next cycle → hazard_b_o=1; RV32E=1 with write to addr 0x13 → rf_waddr_o=3.
- rst_ni low for one cycle in RUN with a write in flight → rf_we_o=0 next cycle, init_done_o=0, and the full sweep repeats.
